// File: rtl/alu_rmw_seq.sv
// alu_rmw_seq: read-modify-write micro-sequencer for 6502 memory-operand
// shifts/rotates and INC/DEC. It reads the operand, runs it through the
// external combinational ALU, writes the unmodified value back (the 6502
// dummy write), writes the result, and hands the new P flags to the core.
module alu_rmw_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] addr,
  input  logic [7:0]  p_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  output logic [3:0]  alu_mode,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_p,
  input  logic [7:0]  alu_ar,
  input  logic [7:0]  alu_af,
  output logic [7:0]  p_out,
  output logic        p_we
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_EXEC   = 3'd2,
    S_WDUMMY = 3'd3,
    S_WFINAL = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      r_state, w_next;

  // Request context latched on accept; later input changes are ignored.
  logic [15:0] r_addr;
  logic [7:0]  r_p;
  logic [3:0]  r_mode;
  logic        r_err;

  // Datapath capture registers.
  logic [7:0]  r_operand;
  logic [7:0]  r_result;
  logic [7:0]  r_flags;

  // ALU drive registers: updated only on entry to EXEC, held otherwise.
  logic [3:0]  r_alu_mode;
  logic [7:0]  r_alu_p;

  logic        w_op_valid;
  logic [3:0]  w_mode;

  // Decode op into ALU mode; codes 6 and 7 are reserved.
  always_comb begin
    w_op_valid = 1'b1;
    w_mode     = 4'b0000;
    case (op)
      3'd0:    w_mode = 4'b1000;  // ASL
      3'd1:    w_mode = 4'b1001;  // ROL
      3'd2:    w_mode = 4'b1010;  // LSR
      3'd3:    w_mode = 4'b1011;  // ROR
      3'd4:    w_mode = 4'b1110;  // DEC
      3'd5:    w_mode = 4'b1111;  // INC
      default: w_op_valid = 1'b0;
    endcase
  end

  // State register plus request/datapath captures; synchronous reset clears all.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_p        <= '0;
      r_mode     <= '0;
      r_err      <= 1'b0;
      r_operand  <= '0;
      r_result   <= '0;
      r_flags    <= '0;
      r_alu_mode <= '0;
      r_alu_p    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_op_valid) begin
              r_addr <= addr;
              r_p    <= p_in;
              r_mode <= w_mode;
              r_err  <= 1'b0;
            end else begin
              r_err  <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (mem_ready) begin
            r_operand  <= mem_rdata;
            r_alu_mode <= r_mode;
            r_alu_p    <= r_p;
          end
        end
        S_EXEC: begin
          r_result <= alu_ar;
          r_flags  <= alu_af;
        end
        default: ;
      endcase
    end
  end

  // Next-state and Moore output decode from the state and capture registers.
  always_comb begin
    w_next    = r_state;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    p_we      = 1'b0;
    p_out     = 8'h00;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = w_op_valid ? S_READ : S_DONE;
      end
      S_READ: begin
        mem_rd = 1'b1;
        if (mem_ready) w_next = S_EXEC;
      end
      S_EXEC: begin
        w_next = S_WDUMMY;
      end
      S_WDUMMY: begin
        mem_wr    = 1'b1;
        mem_wdata = r_operand;
        if (mem_ready) w_next = S_WFINAL;
      end
      S_WFINAL: begin
        mem_wr    = 1'b1;
        mem_wdata = r_result;
        if (mem_ready) w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        err    = r_err;
        p_we   = ~r_err;
        p_out  = r_err ? 8'h00 : r_flags;
        w_next = S_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  assign mem_addr = r_addr;
  assign alu_mode = r_alu_mode;
  assign alu_b    = r_operand;
  assign alu_p    = r_alu_p;

endmodule
